mmio_dot_accum: RTL and testbench

Compute stage directly downstream of the MMIO write FIFO in the ccip_mmio AFU.
- Consumes 64-bit FIFO output words, treating each as 8 signed int8 lanes.
- Forms the dot product of each word with a host-written 64-bit weight word.
- Accumulates the dot products over a host-programmed number of words.
- The AFU MMIO read path returns result, done and overflow to the host.

---
 rtl/dot_pkg.sv | 24 ++
 rtl/dot_prod_stage.sv | 53 +++++
 rtl/mmio_dot_accum.sv | 106 ++++++++++
 tb/tb_mmio_dot_accum.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared constants and types for the MMIO int8 dot-product accumulator.
package dot_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LEN_W  = 8;

    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned PROD_W = 2 * LANE_W;
    // Eight signed 16-bit products need three extra bits to sum without loss.
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } t_dot_state;

    typedef logic signed [PROD_W-1:0] t_prod;
    typedef t_prod [LANES-1:0] t_prod_vec;

endpackage

// File: rtl/dot_prod_stage.sv
// Registered 8-lane signed int8 multiply followed by a combinational lane-sum tree.
module dot_prod_stage
    import dot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    output logic [SUM_W-1:0]  sum
);

    t_prod_vec prod_c;
    t_prod_vec prod;
    logic signed [SUM_W-1:0] pair_sum [LANES/2];
    logic signed [SUM_W-1:0] quad_sum [LANES/4];
    logic signed [SUM_W-1:0] total;

    // Lane products; assignment context widens each signed operand to PROD_W.
    always_comb begin
        prod_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            prod_c[i] = $signed(a[i*LANE_W +: LANE_W]) * $signed(b[i*LANE_W +: LANE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            prod      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod <= prod_c;
            end
        end
    end

    // Three-level balanced tree over sign-extended products.
    always_comb begin
        for (int i = 0; i < int'(LANES / 2); i++) begin
            pair_sum[i] = SUM_W'($signed(prod[2*i])) + SUM_W'($signed(prod[2*i+1]));
        end
        for (int i = 0; i < int'(LANES / 4); i++) begin
            quad_sum[i] = pair_sum[2*i] + pair_sum[2*i+1];
        end
        total = quad_sum[0] + quad_sum[1];
    end

    assign sum = total;

endmodule

// File: rtl/mmio_dot_accum.sv
// Job FSM, word counter and wrapping signed accumulator behind the MMIO write FIFO.
module mmio_dot_accum #(
    parameter int unsigned ACC_W = dot_pkg::ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wgt_wr,
    input  logic [dot_pkg::WORD_W-1:0] wgt_data,
    input  logic                       start,
    input  logic [dot_pkg::LEN_W-1:0]  len,
    input  logic                       in_valid,
    input  logic [dot_pkg::WORD_W-1:0] in_data,
    output logic                       in_ready,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           result,
    output logic                       overflow
);

    import dot_pkg::*;

    t_dot_state              state;
    logic [WORD_W-1:0]       wgt;
    logic [LEN_W-1:0]        remaining;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;

    logic                    accept;
    logic                    idle_like;
    logic                    p_valid;
    logic [SUM_W-1:0]        p_sum;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic                    add_ovf;

    assign in_ready  = (state == RUN) && (remaining != '0);
    assign accept    = in_valid && in_ready;
    assign idle_like = (state == IDLE) || (state == DONE);

    dot_prod_stage u_prod (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .a         (in_data),
        .b         (wgt),
        .out_valid (p_valid),
        .sum       (p_sum)
    );

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    always_comb begin
        sum_ext  = ACC_W'($signed(p_sum));
        acc_next = acc + sum_ext;
        add_ovf  = (acc[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_next[ACC_W-1] != acc[ACC_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wgt       <= '0;
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (idle_like && wgt_wr) begin
                wgt <= wgt_data;
            end
            if (p_valid) begin
                acc <= acc_next;
                if (add_ovf) begin
                    ovf <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        state     <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!p_valid) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign result   = acc;
    assign overflow = ovf;

endmodule

// File: tb/tb_mmio_dot_accum.sv
// Directed bench for mmio_dot_accum: a 32-bit and a 20-bit accumulator share one stimulus.
module tb_mmio_dot_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        wgt_wr;
    logic [63:0] wgt_data;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [63:0] in_data;

    logic        in_ready, busy, done, overflow;
    logic [31:0] result;
    logic        in_ready20, busy20, done20, overflow20;
    logic [19:0] result20;

    int checks = 0;
    int errors = 0;
    int n_acc;
    int pat [5] = '{1, 0, 1, 1, 1};

    always #5 clk = ~clk;

    mmio_dot_accum dut (
        .clk(clk), .rst(rst), .wgt_wr(wgt_wr), .wgt_data(wgt_data),
        .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done),
        .result(result), .overflow(overflow)
    );

    mmio_dot_accum #(.ACC_W(20)) dut20 (
        .clk(clk), .rst(rst), .wgt_wr(wgt_wr), .wgt_data(wgt_data),
        .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready20), .busy(busy20), .done(done20),
        .result(result20), .overflow(overflow20)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; wgt_wr = 1'b0; wgt_data = '0; start = 1'b0; len = '0;
        in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;

        // 1: reset with upstream asserting valid
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_result",   64'(result),   64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // 2: single word, weight loaded in the start cycle
        wgt_wr = 1'b1; wgt_data = 64'h0101_0101_0101_0101; start = 1'b1; len = 8'd1;
        tick();
        wgt_wr = 1'b0; start = 1'b0;
        chk("t2_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 64'h0807_0605_0403_0201;
        chk("t2_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t2_ready_after", 64'(in_ready), 64'd0);
        chk("t2_done_e0", 64'(done), 64'd0);
        tick();
        chk("t2_done_e1", 64'(done), 64'd0);
        tick();
        chk("t2_done_e2", 64'(done), 64'd1);
        chk("t2_busy_e2", 64'(busy), 64'd0);
        chk("t2_result",  64'(result), 64'd36);

        // 3: signed lanes, weight -1
        wgt_wr = 1'b1; wgt_data = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1; len = 8'd2;
        tick();
        wgt_wr = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0202_0202_0202_0202;
        tick(); tick();
        in_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_result",   64'(result),   64'hFFFF_FFE0);
        chk("t3_result20", 64'(result20), 64'hF_FFE0);
        chk("t3_overflow", 64'(overflow), 64'd0);

        // 4: valid gaps, surplus word, start/wgt_wr while running
        wgt_wr = 1'b1; wgt_data = 64'h0101_0101_0101_0101; start = 1'b1; len = 8'd3;
        tick();
        wgt_wr = 1'b0; start = 1'b0;
        in_data = 64'h0101_0101_0101_0101;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i][0];
            start    = (i == 1);
            wgt_wr   = (i == 1);
            len      = (i == 1) ? 8'd7 : 8'd3;
            wgt_data = (i == 1) ? 64'h0202_0202_0202_0202 : 64'h0101_0101_0101_0101;
            if (i == 4) chk("t4_no_ready_surplus", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0; start = 1'b0; wgt_wr = 1'b0; len = 8'd0;
        chk("t4_accepts", 64'(n_acc), 64'd3);
        wait_done("t4_done");
        chk("t4_result", 64'(result), 64'd24);

        // 5: zero-length job
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("t5_done",   64'(done),     64'd1);
        chk("t5_result", 64'(result),   64'd0);
        chk("t5_ready",  64'(in_ready), 64'd0);
        chk("t5_busy",   64'(busy),     64'd0);
        tick();
        chk("t5_ready_later", 64'(in_ready), 64'd0);

        // 6: overflow in the 20-bit accumulator
        wgt_wr = 1'b1; wgt_data = 64'h7F7F_7F7F_7F7F_7F7F; start = 1'b1; len = 8'd5;
        tick();
        wgt_wr = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = 64'h7F7F_7F7F_7F7F_7F7F;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        wait_done("t6_done");
        chk("t6_overflow20", 64'(overflow20), 64'd1);
        chk("t6_result20",   64'(result20),   64'h9_D828);
        chk("t6_result32",   64'(result),     64'h0009_D828);
        chk("t6_overflow32", 64'(overflow),   64'd0);

        // 6b: reset two beats into a restarted job
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("t6_rst_busy",       64'(busy),       64'd0);
        chk("t6_rst_done",       64'(done),       64'd0);
        chk("t6_rst_result",     64'(result),     64'd0);
        chk("t6_rst_result20",   64'(result20),   64'd0);
        chk("t6_rst_overflow20", 64'(overflow20), 64'd0);
        chk("t6_rst_ready",      64'(in_ready),   64'd0);
        rst = 1'b0;
        tick();

        // 6c: clean job after the abort
        wgt_wr = 1'b1; wgt_data = 64'h0101_0101_0101_0101; start = 1'b1; len = 8'd1;
        tick();
        wgt_wr = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0807_0605_0403_0201;
        tick();
        in_valid = 1'b0;
        wait_done("t6c_done");
        chk("t6c_result",     64'(result),     64'd36);
        chk("t6c_result20",   64'(result20),   64'd36);
        chk("t6c_overflow20", 64'(overflow20), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
